// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the OV7670 capture path into the camera ingress FIFO.
package cam_capture_pkg;

    typedef enum logic [2:0] {
        WAIT_CALIB,
        WAIT_VBLANK,
        WAIT_SOF,
        CAPTURE,
        DROP
    } cap_state_e;

    localparam int FIFO_W = 17;
    localparam logic [FIFO_W-1:0] SOF_MARKER = 17'h10000;

    // Counter widths: x saturates at 2047, y at 1023.
    localparam int X_W = 11;
    localparam int Y_W = 10;

    // Eight vertical colour bars, left to right, in RGB565.
    localparam logic [15:0] BAR_RGB565 [0:7] = '{
        16'hFFFF,   // white
        16'hFFE0,   // yellow
        16'h07FF,   // cyan
        16'h07E0,   // green
        16'hF81F,   // magenta
        16'hF800,   // red
        16'h001F,   // blue
        16'h0000    // black
    };

endpackage

// File: rtl/cam_byte_pairer.sv
// Pairs sensor bytes into RGB565 pixels and tracks the pixel column within a line.
// pixel_strobe_o/pixel_o are combinational on the second byte, so the caller can
// register the FIFO word at the same edge and keep write latency to one cycle.
module cam_byte_pairer
    import cam_capture_pkg::*;
(
    input  logic           PixelClk,
    input  logic           nRST,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic           href_i,
    input  logic [7:0]     p_data_i,
    output logic           pixel_strobe_o,
    output logic [15:0]    pixel_o,
    output logic [X_W-1:0] x_o,
    output logic           half_o,
    output logic           line_end_o
);

    logic           href_q;
    logic           half_q;
    logic [7:0]     hi_q;
    logic [X_W-1:0] x_q;

    assign line_end_o     = en_i & href_q & ~href_i;
    assign pixel_strobe_o = en_i & href_i & half_q;
    assign pixel_o        = {hi_q, p_data_i};
    assign x_o            = x_q;
    assign half_o         = half_q;

    // Byte phase, high-byte holding register and saturating column counter.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            href_q <= 1'b0;
            half_q <= 1'b0;
            hi_q   <= 8'h00;
            x_q    <= '0;
        end else begin
            href_q <= href_i;
            if (clr_i) begin
                half_q <= 1'b0;
                x_q    <= '0;
            end else if (en_i) begin
                if (line_end_o) begin
                    half_q <= 1'b0;
                    x_q    <= '0;
                end else if (href_i) begin
                    half_q <= ~half_q;
                    if (!half_q) begin
                        hi_q <= p_data_i;
                    end else if (x_q != '1) begin
                        x_q <= x_q + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cam_capture_sequencer.sv
// OV7670 capture sequencer: waits for PSRAM calibration, aligns to a clean frame
// start, crops the sensor frame to the LCD window and writes a marker plus RGB565
// pixels into the ingress FIFO. Frames that hit FIFO full are dropped whole.
// Optional build macro CAP_TEST_PATTERN_EN adds a test_pattern input that replaces
// pixel data with eight vertical colour bars.
//
// state       | meaning
// WAIT_CALIB  | PSRAM not calibrated yet
// WAIT_VBLANK | waiting for vertical blank so capture never starts mid-frame
// WAIT_SOF    | in blank, waiting for VSYNC fall to start a frame
// CAPTURE     | writing marker and cropped pixels
// DROP        | frame abandoned on FIFO full, waiting for next blank
module cam_capture_sequencer
    import cam_capture_pkg::*;
#(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int CROP_X0      = 80,
    parameter int CROP_Y0      = 104,
    parameter int CROP_W       = 480,
    parameter int CROP_H       = 272
) (
    input  logic              PixelClk,
    input  logic              nRST,
    input  logic              calib_done,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              href,
    input  logic [7:0]        p_data,
    input  logic              fifo_full,
`ifdef CAP_TEST_PATTERN_EN
    input  logic              test_pattern,
`endif
    output logic [FIFO_W-1:0] fifo_data,
    output logic              fifo_wr_en,
    output logic              frame_active,
    output logic              overflow_err,
    output logic              size_err,
    input  logic              clear_err
);

    localparam logic [X_W-1:0] X_LO   = X_W'(CROP_X0);
    localparam logic [X_W-1:0] X_HI   = X_W'(CROP_X0 + CROP_W);
    localparam logic [Y_W-1:0] Y_LO   = Y_W'(CROP_Y0);
    localparam logic [Y_W-1:0] Y_HI   = Y_W'(CROP_Y0 + CROP_H);
    localparam logic [X_W-1:0] X_FULL = X_W'(FRAME_WIDTH);
    localparam logic [Y_W-1:0] Y_FULL = Y_W'(FRAME_HEIGHT);

    if ((CROP_X0 + CROP_W > FRAME_WIDTH) || (CROP_Y0 + CROP_H > FRAME_HEIGHT)) begin : g_bad_geometry
        $fatal(1, "cam_capture_sequencer: crop window exceeds sensor frame");
    end

    cap_state_e        state_q;
    logic [Y_W-1:0]    y_q;
    logic [Y_W-1:0]    y_d;
    logic [FIFO_W-1:0] fifo_data_q;
    logic              wr_en_q;
    logic              ovf_q;
    logic              size_q;

    logic              pix_strobe;
    logic [15:0]       pix_sensor;
    logic [15:0]       pix_word;
    logic [X_W-1:0]    pix_x;
    logic              half;
    logic              line_end;
    logic              in_crop;
    logic              pix_pending;
    logic              line_bad;
    logic              frame_bad;

    cam_byte_pairer u_pairer (
        .PixelClk       (PixelClk),
        .nRST           (nRST),
        .clr_i          (state_q == WAIT_SOF),
        .en_i           (state_q == CAPTURE),
        .href_i         (href),
        .p_data_i       (p_data),
        .pixel_strobe_o (pix_strobe),
        .pixel_o        (pix_sensor),
        .x_o            (pix_x),
        .half_o         (half),
        .line_end_o     (line_end)
    );

    // Crop window decode, geometry checks and pixel source selection.
    always_comb begin
        in_crop     = (pix_x >= X_LO) && (pix_x < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
        pix_pending = pix_strobe && in_crop;
        y_d         = y_q;
        if (line_end && (y_q != '1)) begin
            y_d = y_q + 1'b1;
        end
        line_bad  = line_end && ((pix_x != X_FULL) || half);
        // y_d so a line ending on the same edge as VSYNC rise still counts.
        frame_bad = cam_vsync && (y_d != Y_FULL);
        pix_word  = pix_sensor;
`ifdef CAP_TEST_PATTERN_EN
        if (test_pattern) begin
            pix_word = BAR_RGB565[3'(((int'(pix_x - X_LO)) * 8) / CROP_W)];
        end
`endif
    end

    // Frame sequencing FSM with registered FIFO outputs and sticky error flags.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= WAIT_CALIB;
            y_q         <= '0;
            fifo_data_q <= '0;
            wr_en_q     <= 1'b0;
            ovf_q       <= 1'b0;
            size_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            // Later assignments in the case below override the clear, so a
            // coincident new error stays set.
            if (clear_err) begin
                ovf_q  <= 1'b0;
                size_q <= 1'b0;
            end
            case (state_q)
                WAIT_CALIB: begin
                    if (calib_done) state_q <= WAIT_VBLANK;
                end
                WAIT_VBLANK: begin
                    if (cam_vsync) state_q <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    y_q <= '0;
                    if (!cam_vsync) begin
                        if (!capture_en) begin
                            state_q <= WAIT_VBLANK;
                        end else if (fifo_full) begin
                            ovf_q   <= 1'b1;
                            state_q <= DROP;
                        end else begin
                            wr_en_q     <= 1'b1;
                            fifo_data_q <= SOF_MARKER;
                            state_q     <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    y_q <= y_d;
                    if (line_bad || frame_bad) size_q <= 1'b1;
                    if (pix_pending && fifo_full) begin
                        ovf_q   <= 1'b1;
                        state_q <= DROP;
                    end else begin
                        if (pix_pending) begin
                            wr_en_q     <= 1'b1;
                            fifo_data_q <= {1'b0, pix_word};
                        end
                        if (cam_vsync) state_q <= WAIT_SOF;
                    end
                end
                DROP: begin
                    if (cam_vsync) state_q <= WAIT_SOF;
                end
                default: state_q <= WAIT_CALIB;
            endcase
        end
    end

    assign fifo_data    = fifo_data_q;
    assign fifo_wr_en   = wr_en_q;
    assign frame_active = (state_q == CAPTURE);
    assign overflow_err = ovf_q;
    assign size_err     = size_q;

endmodule

// File: tb/tb_cam_capture_sequencer.sv
// Directed bench for cam_capture_sequencer on a reduced 16x10 sensor frame with an
// 8x5 crop window at (4,2). Build with CAP_TEST_PATTERN_EN to also cover colour bars.
module tb_cam_capture_sequencer;
    import cam_capture_pkg::*;

    localparam int FW  = 16;
    localparam int FH  = 10;
    localparam int CX0 = 4;
    localparam int CY0 = 2;
    localparam int CW  = 8;
    localparam int CH  = 5;
    localparam int GOOD_WORDS = 1 + CW * CH;

    logic        PixelClk   = 1'b0;
    logic        nRST       = 1'b0;
    logic        calib_done = 1'b0;
    logic        capture_en = 1'b0;
    logic        cam_vsync  = 1'b0;
    logic        href       = 1'b0;
    logic [7:0]  p_data     = 8'h00;
    logic        fifo_full  = 1'b0;
    logic        clear_err  = 1'b0;
`ifdef CAP_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif
    logic [16:0] fifo_data;
    logic        fifo_wr_en;
    logic        frame_active;
    logic        overflow_err;
    logic        size_err;

    int          n_vec = 0;
    int          n_err = 0;
    logic [16:0] wr_q[$];

    cam_capture_sequencer #(
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .CROP_X0      (CX0),
        .CROP_Y0      (CY0),
        .CROP_W       (CW),
        .CROP_H       (CH)
    ) dut (
        .PixelClk     (PixelClk),
        .nRST         (nRST),
        .calib_done   (calib_done),
        .capture_en   (capture_en),
        .cam_vsync    (cam_vsync),
        .href         (href),
        .p_data       (p_data),
        .fifo_full    (fifo_full),
`ifdef CAP_TEST_PATTERN_EN
        .test_pattern (test_pattern),
`endif
        .fifo_data    (fifo_data),
        .fifo_wr_en   (fifo_wr_en),
        .frame_active (frame_active),
        .overflow_err (overflow_err),
        .size_err     (size_err),
        .clear_err    (clear_err)
    );

    always #5 PixelClk = ~PixelClk;

    always @(posedge PixelClk) begin
        #1;
        if (fifo_wr_en) wr_q.push_back(fifo_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge PixelClk);
    endtask

    function automatic logic [16:0] exp_pix(input int l, input int c);
        int b;
        b = l * 2 * FW + 2 * c;
        return {1'b0, 8'(b), 8'(b + 1)};
    endfunction

    // One sensor frame: optional vblank, VSYNC fall, FH ramp lines, 3-cycle line gaps.
    task automatic run_frame(input bit vblank, input bit en, input int short_line,
                             input int full_at, input bit exp_marker);
        int b   = 0;
        int pix = 0;
        int w;
        wr_q.delete();
        capture_en = en;
        if (vblank) begin
            fifo_full = 1'b0;
            cam_vsync = 1'b1;
            tick(4);
        end
        cam_vsync = 1'b0;
        tick(1);
        chk("sof_wr_en", fifo_wr_en, exp_marker);
        tick(1);
        for (int l = 0; l < FH; l++) begin
            w = (l == short_line) ? FW - 1 : FW;
            href = 1'b1;
            for (int c = 0; c < w; c++) begin
                if (pix == full_at) fifo_full = 1'b1;
                p_data = 8'(b); tick(1); b++;
                p_data = 8'(b); tick(1); b++;
                pix++;
            end
            href = 1'b0;
            tick(3);
            if (l + 1 == short_line) chk("size_err_pre", size_err, 0);
            if (l == short_line)     chk("size_err_line", size_err, 1);
        end
        tick(2);
    endtask

    task automatic verify_good(input string tag);
        chk({tag, "_count"}, wr_q.size(), GOOD_WORDS);
        if (wr_q.size() == GOOD_WORDS) begin
            chk({tag, "_marker"}, wr_q[0], SOF_MARKER);
            for (int k = 1; k < GOOD_WORDS; k++)
                chk({tag, "_pix"}, wr_q[k], exp_pix(CY0 + (k - 1) / CW, CX0 + (k - 1) % CW));
        end
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_fifo_data", fifo_data, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_active", frame_active, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_size", size_err, 0);
        nRST = 1'b1;
        tick(2);

        // Full frame while PSRAM is still calibrating: ignored.
        run_frame(1, 1, -1, -1, 0);
        chk("calib_hold_count", wr_q.size(), 0);
        calib_done = 1'b1;
        tick(2);

        // Lines with VSYNC low before any blank: capture must not start mid-frame.
        run_frame(0, 1, -1, -1, 0);
        chk("no_vblank_count", wr_q.size(), 0);

        run_frame(1, 1, -1, -1, 1);
        verify_good("ramp");
        chk("ramp_size_err", size_err, 0);
        chk("ramp_ovf", overflow_err, 0);
        chk("ramp_active", frame_active, 1);

        run_frame(1, 1, 3, -1, 1);
        chk("short_count", wr_q.size(), GOOD_WORDS);
        chk("short_size_err", size_err, 1);

        run_frame(1, 1, -1, -1, 1);
        verify_good("after_short");
        chk("size_sticky", size_err, 1);
        pulse_clear();
        chk("size_cleared", size_err, 0);

        // FIFO goes full at pixel 40 = line 2 col 8, inside the crop window.
        run_frame(1, 1, -1, 40, 1);
        chk("ovf_count", wr_q.size(), 5);
        if (wr_q.size() == 5) chk("ovf_last_word", wr_q[4], exp_pix(2, 7));
        chk("ovf_err", overflow_err, 1);
        chk("ovf_drop_active", frame_active, 0);

        run_frame(1, 1, -1, -1, 1);
        verify_good("post_ovf");
        chk("ovf_sticky", overflow_err, 1);
        pulse_clear();
        chk("ovf_cleared", overflow_err, 0);

        run_frame(1, 0, -1, -1, 0);
        chk("skip_count", wr_q.size(), 0);
        chk("skip_active", frame_active, 0);

        run_frame(1, 1, -1, -1, 1);
        verify_good("resume");

`ifdef CAP_TEST_PATTERN_EN
        test_pattern = 1'b1;
        run_frame(1, 1, -1, -1, 1);
        test_pattern = 1'b0;
        chk("tp_count", wr_q.size(), GOOD_WORDS);
        if (wr_q.size() == GOOD_WORDS) begin
            chk("tp_marker", wr_q[0], SOF_MARKER);
            chk("tp_bar0", wr_q[1], 17'h0FFFF);
            chk("tp_bar1", wr_q[2], 17'h0FFE0);
            chk("tp_bar3", wr_q[4], 17'h007E0);
            chk("tp_bar7", wr_q[8], 17'h00000);
        end
`endif

        // Closing blank: complete frame geometry raises no error.
        cam_vsync = 1'b1;
        tick(3);
        chk("final_size_err", size_err, 0);
        chk("final_active", frame_active, 0);

        // Reset in the middle of a frame: no partial frame resumes afterwards.
        cam_vsync = 1'b0;
        tick(2);
        chk("mid_active", frame_active, 1);
        nRST = 1'b0;
        tick(1);
        chk("mid_rst_active", frame_active, 0);
        chk("mid_rst_wr_en", fifo_wr_en, 0);
        nRST = 1'b1;
        run_frame(0, 1, -1, -1, 0);
        chk("mid_rst_count", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
